// File: rtl/shift_pipe_if.sv
// Handshake bundle for the two-stage shift unit: operand side and result side.
interface shift_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    // Upstream/downstream side (drives operations, consumes results).
    modport master (
        output in_valid, data_in, shamt, op, out_ready,
        input  in_ready, out_valid, result
    );

    // Shift unit side.
    modport slave (
        input  in_valid, data_in, shamt, op, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage pipelined 32-bit shifter (SLL / SRA). Stage 1 does the 16/8 steps,
// stage 2 the 4/2/1 steps. Each stage holds one operation; capacity is two.
module shift_pipe (
    input logic         clock,
    input logic         reset_n,
    shift_pipe_if.slave bus
);

    logic        s1_valid;
    logic [31:0] s1_data;
    logic [2:0]  s1_shamt_lo;
    logic        s1_op;
    logic        s2_valid;
    logic [31:0] s2_data;

    logic        s1_adv;
    logic        s2_adv;
    logic [31:0] s1_next;
    logic [31:0] s2_next;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_data;

    // Coarse shift: 16- and 8-bit steps; SRA fills with the operand's sign bit.
    always_comb begin
        logic sgn;
        sgn     = bus.op & bus.data_in[31];
        s1_next = bus.data_in;
        if (bus.shamt[4]) begin
            s1_next = bus.op ? {{16{sgn}}, s1_next[31:16]} : {s1_next[15:0], 16'h0};
        end
        if (bus.shamt[3]) begin
            s1_next = bus.op ? {{8{sgn}}, s1_next[31:8]} : {s1_next[23:0], 8'h0};
        end
    end

    // Fine shift: 4-, 2- and 1-bit steps. Stage 1 keeps bit 31 intact for SRA,
    // so s1_data[31] is still the original sign.
    always_comb begin
        logic sgn;
        sgn     = s1_op & s1_data[31];
        s2_next = s1_data;
        if (s1_shamt_lo[2]) begin
            s2_next = s1_op ? {{4{sgn}}, s2_next[31:4]} : {s2_next[27:0], 4'h0};
        end
        if (s1_shamt_lo[1]) begin
            s2_next = s1_op ? {{2{sgn}}, s2_next[31:2]} : {s2_next[29:0], 2'h0};
        end
        if (s1_shamt_lo[0]) begin
            s2_next = s1_op ? {sgn, s2_next[31:1]} : {s2_next[30:0], 1'b0};
        end
    end

    // Stage 1 register: loads a new operation (or a bubble) whenever it advances.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= 32'h0;
            s1_shamt_lo <= 3'h0;
            s1_op       <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data     <= s1_next;
                s1_shamt_lo <= bus.shamt[2:0];
                s1_op       <= bus.op;
            end
        end
    end

    // Stage 2 register: drives the outputs directly; holds under backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= 32'h0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s2_next;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed cases plus a random regression against an
// arithmetic reference model and an in-order scoreboard.
module tb_shift_pipe;

    logic clock;
    logic reset_n;

    shift_pipe_if bus ();

    shift_pipe dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        int          t;
    } item_t;

    item_t       q[$];
    logic [31:0] popped[$];
    int          n_vec;
    int          n_err;
    int          n_edge;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic o);
        if (o) return 32'($signed(d) >>> s);
        return d << s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check and update the model, then take the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic [4:0] s,
                        input logic o, input logic ordy);
        logic exp_rdy;
        logic exp_vld;
        @(negedge clock);
        bus.in_valid  = iv;
        bus.data_in   = d;
        bus.shamt     = s;
        bus.op        = o;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !(q.size() == 2 && !ordy);
        exp_vld = (q.size() > 0) && (q[0].t < n_edge);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(exp_vld));
        if (exp_vld) check("result", bus.result, q[0].res);
        if (bus.out_valid && ordy && q.size() > 0) begin
            popped.push_back(bus.result);
            void'(q.pop_front());
        end
        if (iv && bus.in_ready) begin
            item_t it;
            it.res = ref_shift(d, s, o);
            it.t   = n_edge + 1;
            q.push_back(it);
        end
        @(posedge clock);
        n_edge++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 5'($urandom), 1'b0, 1'b1);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        n_edge = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = 32'h0;
        bus.shamt     = 5'h0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_result", bus.result, 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic shifts, each with 2-cycle latency
        popped.delete();
        step(1'b1, 32'h80000000, 5'd8, 1'b1, 1'b1);
        step(1'b1, 32'h00000001, 5'd31, 1'b0, 1'b1);
        step(1'b1, 32'h7FFFFFFF, 5'd31, 1'b1, 1'b1);
        idle(3);
        check("basic_count", 32'(popped.size()), 32'd3);
        check("sra_8", popped[0], 32'hFF800000);
        check("sll_31", popped[1], 32'h80000000);
        check("sra_31_pos", popped[2], 32'h00000000);

        // Back-to-back SRA stream
        popped.delete();
        for (int i = 0; i < 32; i++) step(1'b1, 32'hF0F0F0F0, 5'(i), 1'b1, 1'b1);
        idle(3);
        check("stream_count", 32'(popped.size()), 32'd32);
        check("stream_first", popped[0], 32'hF0F0F0F0);
        check("stream_last", popped[31], 32'hFFFFFFFF);

        // Backpressure fill, then simultaneous pop and push
        popped.delete();
        step(1'b1, 32'h1, 5'd4, 1'b0, 1'b0);
        step(1'b1, 32'h1, 5'd5, 1'b0, 1'b0);
        step(1'b1, 32'h1, 5'd6, 1'b0, 1'b0);
        step(1'b1, 32'h1, 5'd6, 1'b0, 1'b0);
        check("bp_held", bus.result, 32'h10);
        step(1'b1, 32'h1, 5'd6, 1'b0, 1'b1);
        idle(3);
        check("bp_count", 32'(popped.size()), 32'd3);
        check("bp_0", popped[0], 32'h10);
        check("bp_1", popped[1], 32'h20);
        check("bp_2", popped[2], 32'h40);

        // Reset mid-operation with two ops in flight
        step(1'b1, 32'h12345678, 5'd3, 1'b0, 1'b0);
        step(1'b1, 32'h87654321, 5'd7, 1'b1, 1'b0);
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_result", bus.result, 32'h0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
        q.delete();
        #1;
        reset_n = 1'b1;
        idle(3);

        // Random regression
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        check("drain_empty", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
